// File: rtl/comparator_3bit_unit.sv
// Registered magnitude comparator: greater/equal/lesser flags plus the index of
// the most significant differing bit, one cycle after the operands are sampled.
module comparator_3bit_unit #(
   parameter int WIDTH = 3,
   parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic             a_greater_b,
   output logic             a_equal_b,
   output logic             a_lesser_b,
   output logic [IDXW-1:0]  msb_diff_idx
);

   // Valid semantics: in_valid qualifies a/b/signed_mode on the same rising edge;
   // out_valid marks the result registers one cycle later. There is no ready
   // signal; every valid input produces a result and nothing ever stalls.

   logic [WIDTH-1:0] diff;
   logic [IDXW-1:0]  idx_c;
   logic             eq_c;
   logic             gt_c;
   logic             lt_c;
   logic             sign_split;

   always_comb begin
      diff  = a ^ b;
      idx_c = '0;
      // Ascending scan so the highest set bit of diff wins.
      for (int i = 0; i < WIDTH; i++) begin
         if (diff[i]) begin
            idx_c = IDXW'(i);
         end
      end
   end

   always_comb begin
      eq_c       = (a == b);
      sign_split = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      // With differing sign bits the non-negative operand (sign 0) is larger,
      // so A is greater exactly when B carries the sign bit.
      gt_c       = sign_split ? b[WIDTH-1] : (a > b);
      lt_c       = ~eq_c & ~gt_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         a_greater_b  <= 1'b0;
         a_equal_b    <= 1'b0;
         a_lesser_b   <= 1'b0;
         msb_diff_idx <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            a_greater_b  <= gt_c;
            a_equal_b    <= eq_c;
            a_lesser_b   <= lt_c;
            msb_diff_idx <= idx_c;
         end
      end
   end

endmodule

// File: tb/tb_comparator_3bit_unit.sv
// Directed bench for comparator_3bit_unit: reset, exhaustive unsigned sweep,
// signed cases, valid gating, narrow-drive compatibility and throughput.
module tb_comparator_3bit_unit;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       signed_mode;
   logic [2:0] a;
   logic [2:0] b;
   logic       out_valid;
   logic       a_greater_b;
   logic       a_equal_b;
   logic       a_lesser_b;
   logic [1:0] msb_diff_idx;

   int total;
   int bad;

   comparator_3bit_unit dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .signed_mode  (signed_mode),
      .a            (a),
      .b            (b),
      .out_valid    (out_valid),
      .a_greater_b  (a_greater_b),
      .a_equal_b    (a_equal_b),
      .a_lesser_b   (a_lesser_b),
      .msb_diff_idx (msb_diff_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Packed view: {out_valid, G, E, L, idx}
   function automatic logic [5:0] observed();
      return {out_valid, a_greater_b, a_equal_b, a_lesser_b, msb_diff_idx};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one set of inputs, clock once, settle away from the edge.
   task automatic step(input logic v, input logic s, input logic [2:0] av, input logic [2:0] bv);
      in_valid    = v;
      signed_mode = s;
      a           = av;
      b           = bv;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] exp_idx(input int av, input int bv);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (((av >> i) & 1) != ((bv >> i) & 1)) begin
            r = 2'(i);
            break;
         end
      end
      return r;
   endfunction

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      signed_mode = 1'b0;
      a           = 3'd0;
      b           = 3'd0;
      #1;
      chk("reset_initial", 32'(observed()), 32'h00);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 3'd0, 3'd0);
      chk("post_reset_idle", 32'(observed()), 32'h00);

      // Mid-run asynchronous reset with G=1 and out_valid=1.
      step(1'b1, 1'b0, 3'd5, 3'd3);
      chk("pre_reset_g", 32'(observed()), {26'd0, 6'b1_100_10});
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", 32'(observed()), 32'h00);
      step(1'b1, 1'b0, 3'd6, 3'd1);
      chk("reset_held", 32'(observed()), 32'h00);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 3'd6, 3'd1);
      chk("released_idle", 32'(observed()), 32'h00);
      step(1'b1, 1'b0, 3'd6, 3'd1);
      chk("first_after_reset", 32'(observed()), {26'd0, 6'b1_100_10});

      // Hand-computed unsigned examples.
      step(1'b1, 1'b0, 3'd5, 3'd3);
      chk("u_5_3", 32'(observed()), {26'd0, 6'b1_100_10});
      step(1'b1, 1'b0, 3'd6, 3'd6);
      chk("u_6_6", 32'(observed()), {26'd0, 6'b1_010_00});
      step(1'b1, 1'b0, 3'd1, 3'd4);
      chk("u_1_4", 32'(observed()), {26'd0, 6'b1_001_10});
      step(1'b1, 1'b0, 3'd2, 3'd3);
      chk("u_2_3", 32'(observed()), {26'd0, 6'b1_001_00});

      // Exhaustive unsigned sweep on consecutive cycles.
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 3'(i), 3'(j));
            chk($sformatf("sweep_%0d_%0d", i, j), 32'(observed()),
                {26'd0, 1'b1, (i > j), (i == j), (i < j), exp_idx(i, j)});
         end
      end

      // Signed mode.
      step(1'b1, 1'b1, 3'b111, 3'b001);
      chk("s_m1_p1", 32'(observed()), {26'd0, 6'b1_001_10});
      step(1'b1, 1'b1, 3'b100, 3'b101);
      chk("s_m4_m3", 32'(observed()), {26'd0, 6'b1_001_00});
      step(1'b1, 1'b1, 3'b011, 3'b100);
      chk("s_p3_m4", 32'(observed()), {26'd0, 6'b1_100_10});
      step(1'b1, 1'b1, 3'b101, 3'b101);
      chk("s_eq", 32'(observed()), {26'd0, 6'b1_010_00});
      step(1'b1, 1'b1, 3'b110, 3'b111);
      chk("s_m2_m1", 32'(observed()), {26'd0, 6'b1_001_00});
      step(1'b1, 1'b0, 3'b111, 3'b001);
      chk("u_7_1", 32'(observed()), {26'd0, 6'b1_100_10});
      step(1'b1, 1'b0, 3'b100, 3'b101);
      chk("u_4_5", 32'(observed()), {26'd0, 6'b1_001_00});

      // Valid gating: flags and idx hold while out_valid drops.
      step(1'b1, 1'b0, 3'd2, 3'd1);
      chk("gate_load", 32'(observed()), {26'd0, 6'b1_100_01});
      step(1'b0, 1'b0, 3'd0, 3'd3);
      chk("gate_hold", 32'(observed()), {26'd0, 6'b0_100_01});
      step(1'b0, 1'b1, 3'd7, 3'd7);
      chk("gate_hold2", 32'(observed()), {26'd0, 6'b0_100_01});

      // Narrow 2-bit drivers, zero-extended.
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, {1'b0, 2'(i)}, {1'b0, 2'(j)});
            chk($sformatf("narrow_%0d_%0d", i, j), 32'({a_greater_b, a_equal_b, a_lesser_b}),
                32'({(i > j), (i == j), (i < j)}));
            chk($sformatf("onehot_%0d_%0d", i, j),
                32'($countones({a_greater_b, a_equal_b, a_lesser_b})), 32'd1);
         end
      end

      // Throughput: 8 back-to-back valid inputs, each result one cycle later.
      step(1'b1, 1'b0, 3'd0, 3'd7);
      chk("tp0", 32'(observed()), {26'd0, 6'b1_001_10});
      step(1'b1, 1'b0, 3'd7, 3'd0);
      chk("tp1", 32'(observed()), {26'd0, 6'b1_100_10});
      step(1'b1, 1'b0, 3'd3, 3'd3);
      chk("tp2", 32'(observed()), {26'd0, 6'b1_010_00});
      step(1'b1, 1'b0, 3'd1, 3'd0);
      chk("tp3", 32'(observed()), {26'd0, 6'b1_100_00});
      step(1'b1, 1'b1, 3'd1, 3'd7);
      chk("tp4", 32'(observed()), {26'd0, 6'b1_100_10});
      step(1'b1, 1'b1, 3'd6, 3'd2);
      chk("tp5", 32'(observed()), {26'd0, 6'b1_001_10});
      step(1'b1, 1'b0, 3'd4, 3'd6);
      chk("tp6", 32'(observed()), {26'd0, 6'b1_001_01});
      step(1'b1, 1'b0, 3'd5, 3'd4);
      chk("tp7", 32'(observed()), {26'd0, 6'b1_100_00});
      step(1'b0, 1'b0, 3'd0, 3'd0);
      chk("tp_drain", 32'(observed()), {26'd0, 6'b0_100_00});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
